// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
//   Bundles the requester-side and RAM-side signals of the frame buffer
//   port arbiter.
//   Requester side: vga_* and sob_* read request/grant/return, wr_* write request/grant.
//   RAM side: mem_read_address, mem_write_address, mem_d, mem_we out; mem_q in.
//   Modports:
//     slave  - the arbiter's view.
//     master - the view of the requesters plus the RAM, which in the bench is one environment.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              sob_req;
  logic [ADDR_W-1:0] sob_addr;
  logic              sob_gnt;
  logic              sob_rvalid;
  logic [DATA_W-1:0] sob_rdata;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  logic [ADDR_W-1:0] mem_read_address;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr, sob_req, sob_addr, wr_req, wr_addr, wr_data, mem_q,
    output vga_gnt, vga_rvalid, vga_rdata, sob_gnt, sob_rvalid, sob_rdata, wr_gnt,
           mem_read_address, mem_write_address, mem_d, mem_we
  );

  modport master (
    output vga_req, vga_addr, sob_req, sob_addr, wr_req, wr_addr, wr_data, mem_q,
    input  vga_gnt, vga_rvalid, vga_rdata, sob_gnt, sob_rvalid, sob_rdata, wr_gnt,
           mem_read_address, mem_write_address, mem_d, mem_we
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single read port of the frame buffer RAM between two requesters.
//   VGA scanout is the high-priority requester.
//   The Sobel window fetcher is the low-priority requester, with a starvation guard.
//   Pixel writes are forwarded onto the RAM write port.
//   All RAM-side signals are registered.
//   Read latency is 3 cycles: accept in N, rvalid in N+3. Throughput is one read per cycle.
//
//   Ports
//     clk   : system clock
//     reset : asynchronous, active-high
//     bus   : fb_port_arbiter_if.slave, which carries vga_*, sob_*, wr_* and mem_*
//
//   Build option: FB_ARB_RR_EN
//     Defined   - round-robin read arbitration with a 1-bit last-winner pointer.
//                 The pointer resets to sob, so vga wins the first conflict.
//     Undefined - fixed VGA priority. Sobel is forced to win after STARVE_MAX
//                 consecutive denied cycles.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 76800,
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          reset,
  fb_port_arbiter_if.slave bus
);
  // Stage 1: the address has been latched. Stage 2: the RAM has sampled it.
  localparam int STAGES = 2;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic sob;  // the return belongs to the Sobel requester
    logic oor;  // the address was out of range, so zero data is returned
  } rd_tag_t;

  logic              vga_win, sob_win, rd_acc, rd_oor, wr_acc, wr_oor;
  logic [ADDR_W-1:0] rd_addr;
  logic [STAGES:1]   vld_pipe;
  rd_tag_t [STAGES:1] tag_pipe;

`ifdef FB_ARB_RR_EN
  logic last_sob;

  // On a conflict, priority goes to whichever requester did not win last.
  assign sob_win = bus.sob_req & (~bus.vga_req | ~last_sob);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_sob <= 1'b1;
    else if (rd_acc) last_sob <= sob_win;
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign sob_win = bus.sob_req & (~bus.vga_req | starved);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           starve_cnt <= '0;
    else if (!bus.sob_req || sob_win)    starve_cnt <= '0;
    else if (!starved)                   starve_cnt <= starve_cnt + SW'(1);
  end
`endif

  assign vga_win = bus.vga_req & ~sob_win;
  assign rd_acc  = (vga_win | sob_win) & ~reset;
  assign rd_addr = sob_win ? bus.sob_addr : bus.vga_addr;
  assign rd_oor  = {1'b0, rd_addr} >= LIMIT;

  // The RAM has no read/write collision handling.
  // A write to the address being read this cycle is refused and retried by the writer.
  assign wr_acc = bus.wr_req & ~reset & ~(rd_acc & (bus.wr_addr == rd_addr));
  assign wr_oor = {1'b0, bus.wr_addr} >= LIMIT;

  // Grants are combinational. They are held low while reset is asserted.
  assign bus.vga_gnt = vga_win & ~reset;
  assign bus.sob_gnt = sob_win & ~reset;
  assign bus.wr_gnt  = wr_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_read_address  <= '0;
      bus.mem_write_address <= '0;
      bus.mem_d             <= '0;
      bus.mem_we            <= 1'b0;
      vld_pipe              <= '0;
      tag_pipe              <= '0;
      bus.vga_rvalid        <= 1'b0;
      bus.sob_rvalid        <= 1'b0;
      bus.vga_rdata         <= '0;
      bus.sob_rdata         <= '0;
    end else begin
      // An out-of-range read never reaches the RAM. Its tag forces zero data on return.
      if (rd_acc && !rd_oor) bus.mem_read_address <= rd_addr;

      // An out-of-range write is accepted and silently dropped.
      bus.mem_we <= wr_acc & ~wr_oor;
      if (wr_acc && !wr_oor) begin
        bus.mem_write_address <= bus.wr_addr;
        bus.mem_d             <= bus.wr_data;
      end

      vld_pipe[1] <= rd_acc;
      tag_pipe[1] <= '{sob: sob_win, oor: rd_oor};
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      // mem_q now holds the data for the stage-2 address.
      bus.vga_rvalid <= vld_pipe[STAGES] & ~tag_pipe[STAGES].sob;
      bus.sob_rvalid <= vld_pipe[STAGES] &  tag_pipe[STAGES].sob;
      if (vld_pipe[STAGES] && !tag_pipe[STAGES].sob)
        bus.vga_rdata <= tag_pipe[STAGES].oor ? '0 : bus.mem_q;
      if (vld_pipe[STAGES] && tag_pipe[STAGES].sob)
        bus.sob_rdata <= tag_pipe[STAGES].oor ? '0 : bus.mem_q;
    end
  end
endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;
  localparam int ADDR_W = 17, DATA_W = 8, DEPTH = 76800, STARVE_MAX = 8;
  localparam logic [16:0] OOR_ADDR = 17'(DEPTH);
`ifdef FB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;

  // The frame buffer RAM: a registered read, with no read/write collision handling.
  logic [7:0] ram    [DEPTH];
  logic [7:0] shadow [DEPTH];
  always @(posedge clk) begin
    bus.mem_q <= ram[bus.mem_read_address];
    if (bus.mem_we) ram[bus.mem_write_address] <= bus.mem_d;
  end

  function automatic logic [7:0] init_val(input int a);
    return (a == 5) ? 8'h3C : 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  // Grant and arbitration rules are applied to the sampled requests.
  // Every read returns three cycles after it is accepted.
  // A read sees every write accepted strictly before it.
  typedef struct {int due; logic [7:0] data;} ret_t;
  ret_t vq[$], sq[$];
  int   cyc = 0, starve = 0;
  bit   last_sob = 1'b1, we_exp = 1'b0, ev, es, ew;
  logic [7:0]  vlast = '0, slast = '0;
  logic [16:0] ra;

  function automatic logic [7:0] model_rd(input logic [16:0] a);
    return (int'(a) >= DEPTH) ? 8'h00 : shadow[a];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      vq.delete(); sq.delete();
      starve = 0; last_sob = 1'b1; we_exp = 1'b0; vlast = '0; slast = '0;
      chk("rst_ctl", 32'({bus.vga_gnt, bus.sob_gnt, bus.wr_gnt, bus.vga_rvalid, bus.sob_rvalid, bus.mem_we}), 32'(0));
      chk("rst_data", 32'({bus.vga_rdata, bus.sob_rdata, bus.mem_d}), 32'(0));
      chk("rst_addr", 32'({bus.mem_read_address != '0, bus.mem_write_address != '0}), 32'(0));
    end else begin
      cyc++;
      if (RR) es = bus.sob_req && (!bus.vga_req || !last_sob);
      else    es = bus.sob_req && (!bus.vga_req || starve == STARVE_MAX);
      ev = bus.vga_req && !es;
      chk("vga_gnt", 32'(bus.vga_gnt), 32'(ev));
      chk("sob_gnt", 32'(bus.sob_gnt), 32'(es));
      ra = es ? bus.sob_addr : bus.vga_addr;
      ew = bus.wr_req && !((ev || es) && bus.wr_addr == ra);
      chk("wr_gnt", 32'(bus.wr_gnt), 32'(ew));
      chk("mem_we", 32'(bus.mem_we), 32'(we_exp));

      while (vq.size() > 0 && vq[0].due < cyc) begin
        chk("vga_rvalid_missed", 32'(vq[0].due), 32'(cyc)); void'(vq.pop_front());
      end
      while (sq.size() > 0 && sq[0].due < cyc) begin
        chk("sob_rvalid_missed", 32'(sq[0].due), 32'(cyc)); void'(sq.pop_front());
      end
      if (vq.size() > 0 && vq[0].due == cyc) begin
        chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(1));
        chk("vga_rdata", 32'(bus.vga_rdata), 32'(vq[0].data));
        vlast = vq[0].data; void'(vq.pop_front());
      end else begin
        chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(0));
        chk("vga_rdata_hold", 32'(bus.vga_rdata), 32'(vlast));
      end
      if (sq.size() > 0 && sq[0].due == cyc) begin
        chk("sob_rvalid", 32'(bus.sob_rvalid), 32'(1));
        chk("sob_rdata", 32'(bus.sob_rdata), 32'(sq[0].data));
        slast = sq[0].data; void'(sq.pop_front());
      end else begin
        chk("sob_rvalid", 32'(bus.sob_rvalid), 32'(0));
        chk("sob_rdata_hold", 32'(bus.sob_rdata), 32'(slast));
      end

      if (ev) vq.push_back(ret_t'{cyc + 3, model_rd(bus.vga_addr)});
      if (es) sq.push_back(ret_t'{cyc + 3, model_rd(bus.sob_addr)});
      we_exp = ew && (int'(bus.wr_addr) < DEPTH);
      if (we_exp) shadow[bus.wr_addr] = bus.wr_data;
      if (!bus.sob_req || es) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      if (ev || es) last_sob = es;
    end
  end

  typedef struct {
    bit vr, sr, wr;
    logic [16:0] va, sa, wa;
    bit gv, gs, gw;
  } vec_t;
  vec_t tv[10];

  task automatic idle();
    bus.vga_req = 1'b0; bus.sob_req = 1'b0; bus.wr_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input bit sob, output int lat, output logic [7:0] d);
    lat = -1; d = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (lat < 0 && (sob ? bus.sob_rvalid : bus.vga_rvalid)) begin
        lat = i; d = sob ? bus.sob_rdata : bus.vga_rdata;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); tick(); reset = 1'b0;
  endtask

  function automatic logic [16:0] rand_addr();
    int r = $urandom_range(0, 15);
    return (r == 15) ? 17'(DEPTH + int'($urandom_range(0, 3))) : 17'(r);
  endfunction

  int lat, first, nsob, nret, k;
  logic [7:0] d;
  bit seen, vg, sg, wg;

  initial begin
    for (int a = 0; a < DEPTH; a++) begin ram[a] = init_val(a); shadow[a] = init_val(a); end
    idle(); bus.vga_addr = '0; bus.sob_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
    tick(); tick(); tick(); reset = 1'b0;

    // Single-cycle grant table. An idle cycle follows every row.
    tv[0] = '{1'b0, 1'b0, 1'b0, 17'd0, 17'd0, 17'd0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 17'd1, 17'd0, 17'd0, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 17'd0, 17'd2, 17'd0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b1, 1'b0, 17'd1, 17'd2, 17'd0, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 17'd0, 17'd0, 17'd7, 1'b0, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b0, 1'b1, 17'd7, 17'd0, 17'd7, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b1, 1'b0, 1'b1, 17'd7, 17'd0, 17'd8, 1'b1, 1'b0, 1'b1};
    tv[7] = '{1'b0, 1'b1, 1'b1, 17'd0, 17'd9, 17'd9, 1'b0, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b0, 1'b1, 17'd0, 17'd0, OOR_ADDR, 1'b0, 1'b0, 1'b1};
    tv[9] = '{1'b1, 1'b0, 1'b1, OOR_ADDR, 17'd0, OOR_ADDR, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.vga_req = tv[i].vr; bus.sob_req = tv[i].sr; bus.wr_req = tv[i].wr;
      bus.vga_addr = tv[i].va; bus.sob_addr = tv[i].sa; bus.wr_addr = tv[i].wa;
      bus.wr_data = 8'(i + 8'h40);
      @(negedge clk);
      chk($sformatf("tv%0d_vga_gnt", i), 32'(bus.vga_gnt), 32'(tv[i].gv));
      chk($sformatf("tv%0d_sob_gnt", i), 32'(bus.sob_gnt), 32'(tv[i].gs));
      chk($sformatf("tv%0d_wr_gnt", i), 32'(bus.wr_gnt), 32'(tv[i].gw));
      tick(); idle(); tick();
    end
    repeat (4) tick();

    // Single VGA read of address 5.
    bus.vga_req = 1'b1; bus.vga_addr = 17'd5;
    @(negedge clk); chk("t1_gnt", 32'(bus.vga_gnt), 32'(1));
    tick(); idle();
    wait_rv(1'b0, lat, d);
    chk("t1_latency", 32'(lat), 32'(3));
    chk("t1_data", 32'(d), 32'(8'h3C));

    // Both requesters held high for 20 cycles.
    do_reset();
    bus.vga_req = 1'b1; bus.vga_addr = 17'd10; bus.sob_req = 1'b1; bus.sob_addr = 17'd20;
    first = -1; nsob = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.sob_gnt) begin nsob++; if (first < 0) first = i; end
      if (first > 0 && i == first + 1) chk("t2_vga_resume", 32'(bus.vga_gnt), 32'(1));
      tick();
    end
    idle();
    chk("t2_first_sob", 32'(first), RR ? 32'(2) : 32'(STARVE_MAX + 1));
    chk("t2_sob_count", 32'(nsob), RR ? 32'(10) : 32'(2));
    repeat (4) tick();

    // A write collides with a Sobel read of the same address.
    bus.sob_req = 1'b1; bus.sob_addr = 17'd100;
    bus.wr_req = 1'b1; bus.wr_addr = 17'd100; bus.wr_data = 8'hA5;
    @(negedge clk);
    chk("t3_wr_blocked", 32'(bus.wr_gnt), 32'(0));
    chk("t3_sob_gnt", 32'(bus.sob_gnt), 32'(1));
    tick(); bus.sob_req = 1'b0;
    @(negedge clk); chk("t3_wr_retry", 32'(bus.wr_gnt), 32'(1));
    tick(); idle();
    wait_rv(1'b1, lat, d);
    chk("t3_lat", 32'(lat), 32'(2));
    chk("t3_old_data", 32'(d), 32'(init_val(100)));
    bus.sob_req = 1'b1; bus.sob_addr = 17'd100;
    @(negedge clk); chk("t3_reread_gnt", 32'(bus.sob_gnt), 32'(1));
    tick(); idle();
    wait_rv(1'b1, lat, d);
    chk("t3_new_data", 32'(d), 32'(8'hA5));

    // Out-of-range read and write.
    bus.vga_req = 1'b1; bus.vga_addr = OOR_ADDR;
    @(negedge clk); chk("t4_rd_gnt", 32'(bus.vga_gnt), 32'(1));
    tick(); idle();
    wait_rv(1'b0, lat, d);
    chk("t4_rd_lat", 32'(lat), 32'(3));
    chk("t4_rd_zero", 32'(d), 32'(0));
    bus.wr_req = 1'b1; bus.wr_addr = OOR_ADDR; bus.wr_data = 8'hFF;
    @(negedge clk); chk("t4_wr_gnt", 32'(bus.wr_gnt), 32'(1));
    tick(); idle(); seen = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.mem_we) seen = 1'b1; tick(); end
    chk("t4_no_we", 32'(seen), 32'(0));

    // Back-to-back VGA reads of addresses 0..3.
    nret = 0;
    for (int i = 0; i <= 10; i++) begin
      bus.vga_req = (i < 4); bus.vga_addr = 17'(i);
      @(negedge clk);
      if (i < 4) chk("t5_gnt", 32'(bus.vga_gnt), 32'(1));
      if (bus.vga_rvalid) begin
        chk("t5_slot", 32'(i), 32'(3 + nret));
        chk("t5_data", 32'(bus.vga_rdata), 32'(init_val(nret)));
        nret++;
      end
      tick();
    end
    idle();
    chk("t5_count", 32'(nret), 32'(4));

    // Reset asserted with two reads in flight.
    bus.vga_req = 1'b1; bus.vga_addr = 17'd1; tick();
    bus.vga_addr = 17'd2; tick();
    reset = 1'b1; bus.vga_addr = 17'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_outs_in_reset", 32'({bus.vga_gnt, bus.vga_rvalid, bus.sob_rvalid, bus.mem_we, bus.vga_rdata}), 32'(0));
      tick();
    end
    reset = 1'b0; idle(); seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (bus.vga_rvalid || bus.sob_rvalid) seen = 1'b1; tick();
    end
    chk("t6_flushed", 32'(seen), 32'(0));

    // Randomised traffic. A request is held until it is granted, or dropped occasionally.
    vg = 1'b0; sg = 1'b0; wg = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.vga_req || vg) begin
        bus.vga_req = ($urandom_range(0, 3) != 0); bus.vga_addr = rand_addr();
      end else if ($urandom_range(0, 7) == 0) bus.vga_req = 1'b0;
      if (!bus.sob_req || sg) begin
        bus.sob_req = ($urandom_range(0, 1) != 0); bus.sob_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) bus.sob_req = 1'b0;
      if (!bus.wr_req || wg) begin
        bus.wr_req = ($urandom_range(0, 1) != 0); bus.wr_addr = rand_addr();
        bus.wr_data = 8'($urandom);
      end
      @(negedge clk);
      vg = bus.vga_gnt; sg = bus.sob_gnt; wg = bus.wr_gnt;
      tick();
    end
    idle();
    repeat (6) tick();
    k = vq.size() + sq.size();
    chk("drain_empty", 32'(k), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
